// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmitter. Takes one word per valid/ready handshake and sends it as
//   a start bit, DATA_BITS data bits LSB first, an optional parity bit and
//   STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (2..65535)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   i_Clk        system clock, rising edge
//   i_Rst        synchronous reset, active high
//   i_TX_Valid   i_TX_Data holds a word to send
//   i_TX_Data    word to send, bit 0 first
//   o_TX_Ready   block accepts a word this cycle (idle and not in reset)
//   o_UART_TX    serial line, idles high, registered
//   o_TX_Active  high from the first start-bit cycle to the last stop-bit cycle
//   o_TX_Done    one-cycle pulse on the last clock of the final stop bit
//
// State table
//   state      | meaning
//   IDLE       | line high, ready for a word; accept latches data and parity
//   START      | line low for one bit time
//   DATA       | line = shreg[0]; shift right at each bit end
//   PARITY_BIT | line = latched parity bit (only when PARITY != 0)
//   STOP       | line high for STOP_BITS bit times; done on the last clock
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_TX_Valid,
  input  logic [DATA_BITS-1:0] i_TX_Data,
  output logic                 o_TX_Ready,
  output logic                 o_UART_TX,
  output logic                 o_TX_Active,
  output logic                 o_TX_Done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST   = 1'(STOP_BITS - 1);

  generate
    if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
      $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535)) begin : g_bad_cpb
      $error("uart_tx_frame: CLKS_PER_BIT must be 2..65535");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_bit;

  assign o_TX_Ready = (state == IDLE) && !i_Rst;

  // o_UART_TX is loaded with the value of the bit that the state is about to
  // enter, so the line always matches the current state with no extra lag.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shreg       <= '0;
      parity_bit  <= 1'b0;
      o_UART_TX   <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_UART_TX   <= 1'b1;
          o_TX_Active <= 1'b0;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          stop_idx    <= 1'b0;
          if (i_TX_Valid) begin
            shreg       <= i_TX_Data;
            parity_bit  <= (PARITY == 1) ? ~^i_TX_Data : ^i_TX_Data;
            o_UART_TX   <= 1'b0;
            o_TX_Active <= 1'b1;
            state       <= START;
          end
        end

        START: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            o_UART_TX <= shreg[0];
            state     <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              if (PARITY != 0) begin
                o_UART_TX <= parity_bit;
                state     <= PARITY_BIT;
              end else begin
                o_UART_TX <= 1'b1;
                stop_idx  <= 1'b0;
                state     <= STOP;
              end
            end else begin
              bit_idx   <= bit_idx + BIT_W'(1);
              shreg     <= shreg >> 1;
              o_UART_TX <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        PARITY_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt   <= '0;
            stop_idx  <= 1'b0;
            o_UART_TX <= 1'b1;
            state     <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          o_UART_TX <= 1'b1;
          // Done is registered, so it is raised one clock early to land on
          // the final stop-bit clock.
          o_TX_Done <= (clk_cnt == CNT_PRELAST) && (stop_idx == STOP_LAST);
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              o_TX_Active <= 1'b0;
              state       <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          o_UART_TX   <= 1'b1;
          o_TX_Active <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Four transmitters share one stimulus stream: 8N1, 8E1, 8O1 and 8N2, all at
//   four clocks per bit. A frame-position model predicts every output on every
//   cycle; a serial receiver decodes the 8N1 line; directed checks pin
//   hand-computed waveform points.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       i_Rst;
  logic       valid;
  logic [7:0] data;
  logic [3:0] rdy, line, act, done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clk(clk), .i_Rst(i_Rst), .i_TX_Valid(valid), .i_TX_Data(data),
    .o_TX_Ready(rdy[0]), .o_UART_TX(line[0]), .o_TX_Active(act[0]), .o_TX_Done(done[0]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_Clk(clk), .i_Rst(i_Rst), .i_TX_Valid(valid), .i_TX_Data(data),
    .o_TX_Ready(rdy[1]), .o_UART_TX(line[1]), .o_TX_Active(act[1]), .o_TX_Done(done[1]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .i_Clk(clk), .i_Rst(i_Rst), .i_TX_Valid(valid), .i_TX_Data(data),
    .o_TX_Ready(rdy[2]), .o_UART_TX(line[2]), .o_TX_Active(act[2]), .o_TX_Done(done[2]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_Clk(clk), .i_Rst(i_Rst), .i_TX_Valid(valid), .i_TX_Data(data),
    .o_TX_Ready(rdy[3]), .o_UART_TX(line[3]), .o_TX_Active(act[3]), .o_TX_Done(done[3]));

  function automatic int par_of(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int len_of(input int k);
    return (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * CPB;
  endfunction

  // Bit-slot list of a frame: slot 0 start, 1..8 data, then parity, then stops.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input int par);
    logic [11:0] b;
    int ones;
    b = '1;
    b[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      b[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (par == 1) b[9] = ((ones % 2) == 0);
    if (par == 2) b[9] = ((ones % 2) == 1);
    return b;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, k, got, exp, $time);
    end
  endtask

  // Frame-position model: m_cyc is the 1-based cycle within the current frame,
  // 0 when idle.
  int          m_cyc  [4];
  logic [11:0] m_bits [4];
  logic [7:0]  m_word [4];
  bit          chk_en = 1'b0;
  int          rst_cnt = 0;

  initial for (int k = 0; k < 4; k++) begin
    m_cyc[k] = 0;
    m_bits[k] = '1;
    m_word[k] = '0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_Rst) m_cyc[k] <= 0;
      else if (m_cyc[k] == 0) begin
        if (valid) begin
          m_cyc[k]  <= 1;
          m_bits[k] <= frame_bits(data, par_of(k));
          m_word[k] <= data;
        end
      end else if (m_cyc[k] == len_of(k)) m_cyc[k] <= 0;
      else m_cyc[k] <= m_cyc[k] + 1;
    end
    if (i_Rst) begin
      chk_en  <= 1'b1;
      rst_cnt <= rst_cnt + 1;
    end
  end

  logic [7:0] rx_q[$];
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_w;
  logic       rx_prev;
  logic       rx_stop;
  int         rx_rc;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        logic exp_line;
        exp_line = (m_cyc[k] == 0) ? 1'b1 : m_bits[k][(m_cyc[k]-1)/CPB];
        chk("line", k, 32'(line[k]), 32'(exp_line));
        chk("active", k, 32'(act[k]), 32'(m_cyc[k] != 0));
        chk("done", k, 32'(done[k]), 32'(m_cyc[k] == len_of(k)));
        chk("ready", k, 32'(rdy[k]), 32'((m_cyc[k] == 0) && !i_Rst));
      end
      if (m_cyc[0] == len_of(0)) begin
        if (rx_q.size() == 0) chk("rx_word_missing", 0, 32'd0, 32'd1);
        else chk("rx_word", 0, 32'(rx_q.pop_front()), 32'(m_word[0]));
      end
    end
  end

  // Serial receiver on the 8N1 line, sampling mid-bit.
  always begin
    @(negedge clk);
    if (chk_en && rx_prev === 1'b1 && line[0] === 1'b0) begin
      rx_rc = rst_cnt;
      repeat (CPB + CPB/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        rx_w[i] = line[0];
        if (i < 7) repeat (CPB) @(negedge clk);
      end
      repeat (CPB) @(negedge clk);
      rx_stop = line[0];
      if (rx_rc == rst_cnt) begin
        chk("rx_stop", 0, 32'(rx_stop), 32'd1);
        rx_q.push_back(rx_w);
        rx_last = rx_w;
      end
    end
    rx_prev = line[0];
  end

  task automatic send(input logic [7:0] d, input bit keep);
    bit got, r;
    got = 1'b0;
    @(posedge clk);
    #1;
    valid = 1'b1;
    data  = d;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      r = rdy[0];
      @(posedge clk);
      if (r) got = 1'b1;
    end
    #1;
    if (!keep) valid = 1'b0;
    chk("send_accept", 0, 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a5_lit;
    int nd, rc;
    a5_lit = 10'b1101001010;
    i_Rst = 1'b1;
    valid = 1'b0;
    data  = 8'h00;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
    chk("rst_line", 0, 32'(line[0]), 32'd1);
    chk("rst_active", 0, 32'(act[0]), 32'd0);
    @(posedge clk);
    #1 i_Rst = 1'b0;

    // 0xA5 on all four variants
    send(8'hA5, 1'b0);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 4) chk("t1_start", 0, 32'(line[0]), 32'd0);
      if (c <= 40 && (c % 4) == 1) chk("t1_bit", 0, 32'(line[0]), 32'(a5_lit[(c-1)/4]));
      if (c == 39) chk("t1_done_early", 0, 32'(done[0]), 32'd0);
      if (c == 40) begin
        chk("t1_done", 0, 32'(done[0]), 32'd1);
        chk("t1_ready_busy", 0, 32'(rdy[0]), 32'd0);
        chk("t1_active", 0, 32'(act[0]), 32'd1);
      end
      if (c == 41) begin
        chk("t1_ready", 0, 32'(rdy[0]), 32'd1);
        chk("t1_active_off", 0, 32'(act[0]), 32'd0);
      end
      if (c == 37) begin
        chk("t2_even_a5", 1, 32'(line[1]), 32'd0);
        chk("t2_odd_a5", 2, 32'(line[2]), 32'd1);
        chk("t3_stop_first", 3, 32'(line[3]), 32'd1);
      end
      if (c == 44) begin
        chk("t2_done44", 1, 32'(done[1]), 32'd1);
        chk("t3_stop_last", 3, 32'(line[3]), 32'd1);
        chk("t3_done44", 3, 32'(done[3]), 32'd1);
      end
      if (c == 45) chk("t3_ready45", 3, 32'(rdy[3]), 32'd1);
    end

    // Parity of 0x07 and 0x00
    send(8'h07, 1'b0);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 37) begin
        chk("t2_even_07", 1, 32'(line[1]), 32'd1);
        chk("t2_odd_07", 2, 32'(line[2]), 32'd0);
      end
    end
    send(8'h00, 1'b0);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 37) begin
        chk("t2_even_00", 1, 32'(line[1]), 32'd0);
        chk("t2_odd_00", 2, 32'(line[2]), 32'd1);
      end
    end

    // Back-to-back with valid held
    send(8'h11, 1'b1);
    data = 8'h22;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      if (c == 40) chk("t4_done", 0, 32'(done[0]), 32'd1);
      if (c == 41) begin
        chk("t4_gap_line", 0, 32'(line[0]), 32'd1);
        chk("t4_gap_ready", 0, 32'(rdy[0]), 32'd1);
      end
      if (c == 42) chk("t4_next_start", 0, 32'(line[0]), 32'd0);
    end
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (46) @(negedge clk);
    chk("t4_rx_second", 0, 32'(rx_last), 32'h22);

    // Reset mid-DATA, then a clean word
    send(8'h3C, 1'b0);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1 i_Rst = 1'b1;
    @(negedge clk);
    chk("t5_ready_in_rst", 0, 32'(rdy[0]), 32'd0);
    @(posedge clk);
    #1 i_Rst = 1'b0;
    @(negedge clk);
    chk("t5_line", 0, 32'(line[0]), 32'd1);
    chk("t5_active", 0, 32'(act[0]), 32'd0);
    chk("t5_done", 0, 32'(done[0]), 32'd0);
    nd = 0;
    repeat (50) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    chk("t5_no_done", 0, 32'(nd), 32'd0);
    send(8'h5A, 1'b0);
    repeat (46) @(negedge clk);
    chk("t5_rx_after_rst", 0, 32'(rx_last), 32'h5A);

    // Data toggling during the frame, valid held throughout
    send(8'h96, 1'b1);
    rc = 0;
    for (int c = 1; c <= 40; c++) begin
      data = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (c < 40 && rdy[0]) rc++;
      if (c == 40) chk("t6_rx_first", 0, 32'(rx_last), 32'h96);
      @(posedge clk);
      #1;
    end
    chk("t6_ready_low", 0, 32'(rc), 32'd0);
    for (int c = 0; c < 50; c++) begin
      data = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    repeat (60) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
